// File: rtl/som_pixel_fetch_if.sv
// Bundle of the RAM_IF read port and the pixel valid/ready stream of som_pixel_fetch.
// master = the fetch block, slave = RAM model / pixel consumer.
interface som_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [23:0]       RAM_IF_Q;
  logic              RAM_IF_OE;
  logic              RAM_IF_WE;
  logic [ADDR_W-1:0] RAM_IF_A;
  logic [23:0]       RAM_IF_D;
  logic [23:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;
  logic [7:0]        epoch;

  modport master (
    input  RAM_IF_Q, pix_ready,
    output RAM_IF_OE, RAM_IF_WE, RAM_IF_A, RAM_IF_D, pix_data, pix_valid, pix_last, epoch
  );

  modport slave (
    output RAM_IF_Q, pix_ready,
    input  RAM_IF_OE, RAM_IF_WE, RAM_IF_A, RAM_IF_D, pix_data, pix_valid, pix_last, epoch
  );
endinterface

// File: rtl/som_pixel_fetch.sv
// Streams pixels from RAM_IF in address order for N_EPOCH passes, hiding the one-cycle
// read latency behind a 4-entry credit-managed prefetch FIFO.
module som_pixel_fetch #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned N_PIXEL = 16384,
  parameter int unsigned N_EPOCH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  som_pixel_fetch_if.master  bus,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(N_PIXEL - 1);
  localparam logic [7:0]        LastEpoch = 8'(N_EPOCH - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            r_state;
  logic              r_busy, r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_epoch;
  // Read in flight towards the RAM (r_oe) and read data arriving this cycle (r_p1_vld).
  logic              r_oe, r_oe_last;
  logic [ADDR_W-1:0] r_a;
  logic [7:0]        r_oe_epoch;
  logic              r_p1_vld, r_p1_last;
  logic [7:0]        r_p1_epoch;

  logic [32:0]       r_mem [4];
  logic [1:0]        r_wptr, r_rptr;
  logic [2:0]        r_count;

  logic              w_push, w_pop, w_credit, w_issue, w_cur_last, w_final, w_drained;
  logic [3:0]        w_inflight;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [7:0]        w_cur_epoch;

  always_comb begin
    w_push      = r_p1_vld;
    w_pop       = (r_count != 3'd0) && bus.pix_ready;
    w_inflight  = 4'(r_count) + 4'(r_oe) + 4'(r_p1_vld);
    w_credit    = (w_inflight - 4'(w_pop)) < 4'd4;
    // Counters are treated as cleared while idle so the first read can go out on start.
    w_cur_addr  = (r_state == StIdle) ? '0 : r_addr;
    w_cur_epoch = (r_state == StIdle) ? '0 : r_epoch;
    w_cur_last  = (w_cur_addr == LastAddr);
    w_final     = w_cur_last && (w_cur_epoch == LastEpoch);
    w_issue     = ((r_state == StIdle) && start) || ((r_state == StIssue) && w_credit);
    w_drained   = !r_oe && !r_p1_vld &&
                  ((r_count == 3'd0) || ((r_count == 3'd1) && w_pop));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_epoch    <= '0;
      r_oe       <= 1'b0;
      r_a        <= '0;
      r_oe_last  <= 1'b0;
      r_oe_epoch <= '0;
      r_p1_vld   <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_epoch <= '0;
    end else begin
      r_oe       <= w_issue;
      r_p1_vld   <= r_oe;
      r_p1_last  <= r_oe_last;
      r_p1_epoch <= r_oe_epoch;
      r_done     <= 1'b0;
      if (w_issue) begin
        r_a        <= w_cur_addr;
        r_oe_last  <= w_cur_last;
        r_oe_epoch <= w_cur_epoch;
        if (w_cur_last) begin
          r_addr  <= '0;
          r_epoch <= w_cur_epoch + 8'd1;
        end else begin
          r_addr  <= w_cur_addr + ADDR_W'(1);
          r_epoch <= w_cur_epoch;
        end
      end
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= w_final ? StDrain : StIssue;
            r_busy  <= 1'b1;
          end
        end
        StIssue: begin
          if (w_issue && w_final) r_state <= StDrain;
        end
        StDrain: begin
          // Leave on the edge that pops the last pixel so done lands right after it.
          if (w_drained) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {bus.RAM_IF_Q, r_p1_last, r_p1_epoch};
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Credit accounting keeps occupancy + outstanding <= 4, so a full FIFO never sees a push.
  assert property (@(posedge clk) disable iff (!rst) !(w_push && (r_count == 3'd4)));

  assign bus.RAM_IF_OE = r_oe;
  assign bus.RAM_IF_A  = r_a;
  assign bus.RAM_IF_WE = 1'b0;
  assign bus.RAM_IF_D  = '0;
  assign bus.pix_valid = (r_count != 3'd0);
  assign bus.pix_data  = r_mem[r_rptr][32:9];
  assign bus.pix_last  = r_mem[r_rptr][8];
  assign bus.epoch     = r_mem[r_rptr][7:0];
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_som_pixel_fetch.sv
// Scoreboard bench for som_pixel_fetch: a 16x2 instance for streaming/backpressure/random/reset
// and a 1x3 instance for the single-pixel-image and start-while-busy cases.
module tb_som_pixel_fetch;
  localparam int unsigned AW  = 18;
  localparam int unsigned NPA = 16;
  localparam int unsigned NEA = 2;
  localparam int unsigned NPB = 1;
  localparam int unsigned NEB = 3;

  logic clk, rst;
  logic a_start, a_busy, a_done;
  logic b_start, b_busy, b_done;

  som_pixel_fetch_if #(.ADDR_W(AW)) a_if ();
  som_pixel_fetch_if #(.ADDR_W(AW)) b_if ();

  som_pixel_fetch #(.ADDR_W(AW), .N_PIXEL(NPA), .N_EPOCH(NEA)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .bus(a_if.master), .busy(a_busy), .done(a_done)
  );

  som_pixel_fetch #(.ADDR_W(AW), .N_PIXEL(NPB), .N_EPOCH(NEB)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .bus(b_if.master), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: data = address * 3, one cycle after the sampling edge.
  always @(posedge clk) if (a_if.RAM_IF_OE) a_if.RAM_IF_Q <= 24'(a_if.RAM_IF_A * 24'd3);
  always @(posedge clk) if (b_if.RAM_IF_OE) b_if.RAM_IF_Q <= 24'(b_if.RAM_IF_A * 24'd3);

  int n_cmp, n_fail;
  int a_acc, b_acc, a_done_cnt, b_done_cnt;
  logic [32:0] a_q[$];
  logic [32:0] b_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: run of N*E pixels, pixel i is address i%N of epoch i/N.
  task automatic push_exp_a();
    for (int i = 0; i < int'(NPA * NEA); i++) begin
      int addr = i % int'(NPA);
      int ep   = i / int'(NPA);
      a_q.push_back({24'(addr * 3), (addr == int'(NPA) - 1), 8'(ep)});
    end
  endtask

  task automatic push_exp_b();
    for (int i = 0; i < int'(NPB * NEB); i++) begin
      int addr = i % int'(NPB);
      int ep   = i / int'(NPB);
      b_q.push_back({24'(addr * 3), (addr == int'(NPB) - 1), 8'(ep)});
    end
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    push_exp_a();
  endtask

  task automatic wait_done_a(input int limit, output int k_done);
    k_done = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (a_done) begin
        k_done = k;
        break;
      end
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ctrl"}, 64'({a_if.RAM_IF_OE, a_if.RAM_IF_WE, a_if.pix_valid, a_if.pix_last,
                                a_busy, a_done}), 64'd0);
    check({tag, "_addr"}, 64'(a_if.RAM_IF_A), 64'd0);
    check({tag, "_data"}, 64'({a_if.pix_data, a_if.epoch, a_if.RAM_IF_D}), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst && a_if.pix_valid && a_if.pix_ready) begin
      a_acc++;
      if (a_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL a_extra_pixel: got 0x%0h, want no pixel", a_if.pix_data);
      end else begin
        check("a_pixel", 64'({a_if.pix_data, a_if.pix_last, a_if.epoch}), 64'(a_q.pop_front()));
      end
    end
    if (a_done) a_done_cnt++;
  end

  always @(negedge clk) begin
    if (rst && b_if.pix_valid && b_if.pix_ready) begin
      b_acc++;
      if (b_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b_extra_pixel: got 0x%0h, want no pixel", b_if.pix_data);
      end else begin
        check("b_pixel", 64'({b_if.pix_data, b_if.pix_last, b_if.epoch}), 64'(b_q.pop_front()));
      end
    end
    if (b_done) b_done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int first_v, done_k, gaps, oe_hi, oe_win, kd, acc0, dc, busy0;
    n_cmp = 0; n_fail = 0; a_acc = 0; b_acc = 0; a_done_cnt = 0; b_done_cnt = 0;
    rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
    a_if.pix_ready = 1'b0; b_if.pix_ready = 1'b0;
    a_if.RAM_IF_Q = '0; b_if.RAM_IF_Q = '0;

    // Reset and idle.
    repeat (3) tick();
    check_reset_a("rst_hold");
    rst = 1'b1;
    a_if.pix_ready = 1'b1;
    oe_hi = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (a_if.RAM_IF_OE || b_if.RAM_IF_OE) oe_hi++;
    end
    check("idle_oe_never", 64'(oe_hi), 64'd0);
    check_reset_a("idle");

    // Streaming, pix_ready held high.
    start_a();
    first_v = -1; done_k = -1; gaps = 0; oe_hi = 0; busy0 = int'(a_busy);
    for (int k = 0; k < 200 && done_k < 0; k++) begin
      if (k > 0) tick();
      if (a_if.pix_valid && first_v < 0) first_v = k;
      if (k >= 2 && k <= 33 && !a_if.pix_valid) gaps++;
      if (a_if.RAM_IF_OE) oe_hi++;
      if (a_done) done_k = k;
    end
    check("stream_busy", 64'(busy0), 64'd1);
    check("stream_first_valid", 64'(first_v), 64'd2);
    check("stream_valid_gaps", 64'(gaps), 64'd0);
    check("stream_oe_cycles", 64'(oe_hi), 64'd32);
    check("stream_done_cycle", 64'(done_k), 64'd34);
    tick();
    check("stream_done_pulse", 64'({a_done, a_busy}), 64'd0);
    check("stream_sb_empty", 64'(a_q.size()), 64'd0);
    check("stream_done_count", 64'(a_done_cnt), 64'd1);

    // Backpressure: ready low for 10 cycles from cycle 3.
    tick();
    start_a();
    tick(); tick();
    a_if.pix_ready = 1'b0;
    oe_win = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (a_if.RAM_IF_OE) oe_win++;
    end
    check("bp_reads_after_stall", 64'(oe_win <= 2), 64'd1);
    check("bp_full_oe_low", 64'({a_if.RAM_IF_OE, a_if.pix_valid}), 64'b01);
    a_if.pix_ready = 1'b1;
    tick();
    check("bp_resume_oe", 64'(a_if.RAM_IF_OE), 64'd1);
    wait_done_a(100, kd);
    check("bp_done_cycle", 64'(kd + 13), 64'd44);
    tick();
    check("bp_sb_empty", 64'(a_q.size()), 64'd0);

    // Random pix_ready over 32 runs (1024 pixels).
    acc0 = a_acc;
    for (int r = 0; r < 32; r++) begin
      a_if.pix_ready = 1'($urandom_range(0, 1));
      start_a();
      kd = -1;
      for (int k = 1; k <= 400; k++) begin
        a_if.pix_ready = 1'($urandom_range(0, 1));
        tick();
        if (a_done) begin
          kd = k;
          break;
        end
      end
      if (kd < 0) check("rand_done_timeout", 64'(kd), 64'd0);
      tick();
    end
    check("rand_pixel_total", 64'(a_acc - acc0), 64'd1024);
    check("rand_sb_empty", 64'(a_q.size()), 64'd0);

    // Reset mid-run after 5 accepted pixels.
    a_if.pix_ready = 1'b1;
    acc0 = a_acc;
    start_a();
    for (int k = 0; k < 50 && (a_acc - acc0) < 5; k++) tick();
    check("mid_acc_reached", 64'((a_acc - acc0) >= 5), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_a("mid_rst");
    a_q.delete();
    b_q.delete();
    dc = a_done_cnt;
    repeat (3) tick();
    rst = 1'b1;
    oe_hi = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (a_if.RAM_IF_OE || a_if.pix_valid) oe_hi++;
    end
    check("mid_no_activity", 64'(oe_hi), 64'd0);
    check("mid_no_done", 64'(a_done_cnt - dc), 64'd0);
    start_a();
    wait_done_a(100, kd);
    check("mid_restart_done", 64'(kd), 64'd34);
    tick();
    check("mid_sb_empty", 64'(a_q.size()), 64'd0);

    // Single-pixel image, three epochs, with a start while busy.
    b_if.pix_ready = 1'b1;
    dc = b_done_cnt;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    push_exp_b();
    tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    kd = -1;
    for (int k = 3; k <= 40; k++) begin
      tick();
      if (b_done && kd < 0) kd = k;
    end
    check("b_done_cycle", 64'(kd), 64'd5);
    check("b_done_count", 64'(b_done_cnt - dc), 64'd1);
    check("b_pixel_count", 64'(b_acc), 64'd3);
    check("b_sb_empty", 64'(b_q.size()), 64'd0);
    check("b_idle_after", 64'({b_busy, b_if.RAM_IF_OE, b_if.pix_valid}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
